// File: rtl/count_display_pkg.sv
// Shared types and constants for the count_display block: FSM states,
// active-low seven-segment glyphs, anode patterns and a BCD adjust helper.
package count_display_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 once doubled.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/count_display_if.sv
// Signal bundle between the counter side (master) and the display stage (slave).
// bcd_valid is a one-cycle strobe with no back-pressure: bcd is stable from that cycle until the next strobe.
interface count_display_if;
    import count_display_pkg::*;

    logic [7:0]  count;
    logic        direction;
    logic        pause;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] bcd;
    logic        bcd_valid;
    state_t      dbg_state;

    modport master (
        output count, direction, pause,
        input  an, seg, dp, bcd, bcd_valid, dbg_state
    );

    modport slave (
        input  count, direction, pause,
        output an, seg, dp, bcd, bcd_valid, dbg_state
    );

endinterface

// File: rtl/count_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a};
// non-decimal codes and the blank flag both give an unlit digit.
module seg7_decode
    import count_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/count_display.sv
// Display stage: sequential double-dabble of count into BCD, then a 4-digit multiplexed scan.
// Define COUNT_DISPLAY_LZB_EN to blank leading zeros on the hundreds and tens digits.
module count_display
    import count_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst,
    count_display_if.slave  bus
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_last_loaded;
    logic [7:0]  r_shift;
    logic [11:0] r_scratch;
    logic [2:0]  r_iter;
    logic [11:0] r_bcd;
    logic        r_bcd_valid;
    logic [11:0] w_adj;
    logic [19:0] w_shifted;

    assign w_adj     = {add3(r_scratch[11:8]), add3(r_scratch[7:4]), add3(r_scratch[3:0])};
    assign w_shifted = {w_adj[10:0], r_shift, 1'b0};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.count != r_last_loaded) w_state_next = CONV;
            CONV:    if (r_iter == 3'd7) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_last_loaded <= 8'd0;
            r_shift       <= 8'd0;
            r_scratch     <= 12'd0;
            r_iter        <= 3'd0;
            r_bcd         <= 12'd0;
            r_bcd_valid   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Changes seen while busy are only picked up here, so only the newest value converts.
                    if (bus.count != r_last_loaded) begin
                        r_shift       <= bus.count;
                        r_last_loaded <= bus.count;
                        r_scratch     <= 12'd0;
                        r_iter        <= 3'd0;
                    end
                end
                CONV: begin
                    r_scratch <= w_shifted[19:8];
                    r_shift   <= w_shifted[7:0];
                    r_iter    <= r_iter + 3'd1;
                end
                DONE: begin
                    r_bcd       <= r_scratch;
                    r_bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [RW-1:0] r_refresh;
    logic [1:0]    r_sel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_refresh <= '0;
            r_sel     <= 2'd0;
        end else if (r_refresh == REFRESH_MAX) begin
            r_refresh <= '0;
            r_sel     <= r_sel + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    logic [3:0] w_nibble;
    logic       w_blank;
    logic [6:0] w_dec_seg;
    logic [6:0] w_seg_next;
    logic [3:0] w_an_next;
    logic       w_hund_zero;
    logic       w_tens_zero;

    assign w_hund_zero = (r_bcd[11:8] == 4'd0);
    assign w_tens_zero = (r_bcd[7:4] == 4'd0);

    always_comb begin
        w_nibble  = r_bcd[3:0];
        w_blank   = 1'b0;
        w_an_next = AN_DIG0;
        case (r_sel)
            2'd0: begin
                w_nibble  = r_bcd[3:0];
                w_an_next = AN_DIG0;
            end
            2'd1: begin
                w_nibble  = r_bcd[7:4];
                w_an_next = AN_DIG1;
`ifdef COUNT_DISPLAY_LZB_EN
                w_blank   = w_hund_zero && w_tens_zero;
`else
                w_blank   = 1'b0;
`endif
            end
            2'd2: begin
                w_nibble  = r_bcd[11:8];
                w_an_next = AN_DIG2;
`ifdef COUNT_DISPLAY_LZB_EN
                w_blank   = w_hund_zero;
`else
                w_blank   = 1'b0;
`endif
            end
            default: begin
                w_nibble  = 4'd0;
                w_an_next = AN_DIG3;
            end
        endcase
    end

    seg7_decode u_seg7_decode (
        .i_bcd   (w_nibble),
        .i_blank (w_blank),
        .o_seg   (w_dec_seg)
    );

    // Digit 3 carries the live direction glyph rather than a numeral.
    assign w_seg_next = (r_sel == 2'd3) ? (bus.direction ? SEG_U : SEG_D) : w_dec_seg;

    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic       r_dp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= !((r_sel == 2'd3) && bus.pause);
        end
    end

    assign bus.an        = r_an;
    assign bus.seg       = r_seg;
    assign bus.dp        = r_dp;
    assign bus.bcd       = r_bcd;
    assign bus.bcd_valid = r_bcd_valid;
    assign bus.dbg_state = r_state;

endmodule
